// File: rtl/pipe_hazard_ctrl.sv
// Y-86 five-stage pipeline control: per-register stall/bubble decisions, a sticky
// RUN/EXC/HALT state machine and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int          CNT_W    = 32,
  parameter logic [3:0]  STAT_AOK = 4'b1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_destM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic [3:0]       W_icode,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic [1:0]       cpu_state,
  output logic             halted,
  output logic [3:0]       final_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_EXC  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] final_nxt;
  logic       lu;
  logic       rt;
  logic       mp;
  logic       advance;

  // Hazard terms: load/use, ret in flight, mispredicted conditional jump.
  always_comb begin
    lu = ((E_icode == I_MRMOVL) || (E_icode == I_POPL)) && (E_destM != R_NONE) &&
         ((E_destM == d_srcA) || (E_destM == d_srcB));
    rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mp = (E_icode == I_JXX) && !e_Cnd;
  end

  // Only RUN and EXC advance; an unused encoding behaves like HALT.
  assign advance = run_en && ((state == ST_RUN) || (state == ST_EXC));

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    if (!advance) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_stall = 1'b1;
    end else if (state == ST_RUN) begin
      F_stall  = lu || rt;
      D_stall  = lu;
      D_bubble = mp || (rt && !lu);
      E_bubble = mp || lu;
      set_cc   = (E_icode == I_OPL) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);
    end else begin
      // Exception drain: younger stages keep resolving hazards, stall beats bubble.
      F_stall  = 1'b1;
      D_stall  = lu;
      D_bubble = (mp || (rt && !lu)) && !lu;
      E_bubble = mp || lu;
      M_bubble = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    final_nxt = final_stat;
    if (advance) begin
      if (W_stat != STAT_AOK) begin
        state_nxt = ST_HALT;
        final_nxt = W_stat;
      end else if ((state == ST_RUN) && (m_stat != STAT_AOK)) begin
        state_nxt = ST_EXC;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_RUN;
      final_stat <= STAT_AOK;
    end else begin
      state      <= state_nxt;
      final_stat <= final_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
      bubble_cnt  <= '0;
      stall_cnt   <= '0;
    end else if (advance) begin
      if (cycle_cnt != CNT_MAX)
        cycle_cnt <= cycle_cnt + CNT_ONE;
      if ((W_icode != I_NOP) && (W_stat == STAT_AOK) && (retired_cnt != CNT_MAX))
        retired_cnt <= retired_cnt + CNT_ONE;
      if ((D_bubble || E_bubble || M_bubble) && (bubble_cnt != CNT_MAX))
        bubble_cnt <= bubble_cnt + CNT_ONE;
      if (F_stall && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign cpu_state = state;
  assign halted    = (state == ST_HALT);

endmodule
